// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the prefetching instruction-fetch unit.
//   fetch_entry_t  : one fetch-queue entry {pc, inst, fault} at the default 32-bit widths
//   AXI_RESP_*     : AXI read-response encodings
//   IFU_RESET_PC   : default first fetch address
//   NOP_INST       : instruction presented while the fetch queue is empty (addi x0,x0,0)
package ifu_pkg;

  localparam int unsigned IFU_PC_W   = 32;
  localparam int unsigned IFU_INST_W = 32;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [IFU_PC_W-1:0]   IFU_RESET_PC = 32'h8000_0000;
  localparam logic [IFU_INST_W-1:0] NOP_INST     = 32'h0000_0013;

  typedef struct packed {
    logic [IFU_PC_W-1:0]   pc;
    logic [IFU_INST_W-1:0] inst;
    logic                  fault;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: synchronous fetch-queue FIFO with flush.
//   clk_i, rst_i        : clock, asynchronous active-low reset (pointers/count only)
//   push_i, push_data_i : enqueue one entry (ignored when full)
//   pop_i               : dequeue head entry (ignored when empty)
//   flush_i             : discard all entries; wins over push/pop in the same cycle
//   head_o              : entry at the head of the queue (stale when empty)
//   count_o, empty_o, full_o : occupancy status
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter type         entry_t = fetch_entry_t,
  parameter int unsigned DEPTH   = 4,
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  entry_t           push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output entry_t           head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push_i & ~full_o;
    do_pop   = pop_i & ~empty_o;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data_i;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only; validity is tracked by the pointers and count.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: instruction-fetch unit keeping up to MAX_OUTSTANDING sequential AXI-lite
// reads in flight and buffering returned instructions in a FIFO_DEPTH-entry queue for decode.
//   clk_i, rst_i                    : clock, asynchronous active-low reset
//   redirect_valid_i, redirect_pc_i : restart the fetch stream at a new word-aligned PC
//   f_valid_o, D_ready_i            : decode handshake for the head entry
//   pc_o, inst_o, fault_o           : head entry (RESET_PC / NOP when empty)
//   mst_ar_*                        : AXI-lite read-address channel (master side)
//   mst_r_*                         : AXI-lite read-data channel (master side)
// Build option: define IFU_ACCESS_FAULT_EN to store a bus-error flag per entry and drive
// fault_o from the head; otherwise the response code is ignored and fault_o is tied low.
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter int unsigned     PC_W            = 32,
  parameter int unsigned     INST_W          = 32,
  parameter int unsigned     FIFO_DEPTH      = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2,
  parameter logic [PC_W-1:0] RESET_PC        = IFU_RESET_PC
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              redirect_valid_i,
  input  logic [PC_W-1:0]   redirect_pc_i,
  output logic              f_valid_o,
  input  logic              D_ready_i,
  output logic [PC_W-1:0]   pc_o,
  output logic [INST_W-1:0] inst_o,
  output logic              fault_o,
  output logic              mst_ar_valid_o,
  output logic [PC_W-1:0]   mst_ar_addr_o,
  input  logic              mst_ar_ready_i,
  input  logic              mst_r_valid_i,
  input  logic [INST_W-1:0] mst_r_data_i,
  input  logic [1:0]        mst_r_resp_i,
  output logic              mst_r_ready_o
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

`ifdef IFU_ACCESS_FAULT_EN
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              fault;
  } entry_t;
`else
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } entry_t;
`endif

  logic [PC_W-1:0]  fpc_q, fpc_d;
  logic [PC_W-1:0]  enq_pc_q, enq_pc_d;
  logic [PC_W-1:0]  ar_addr_q, ar_addr_d;
  logic             ar_valid_q, ar_valid_d;
  logic [OUT_W-1:0] outstanding_q, outstanding_d;
  logic [OUT_W-1:0] drop_q, drop_d;

  logic             ar_hs, r_hs, push, pop;
  logic [PC_W-1:0]  fetch_pc;
  logic [CNT_W-1:0] fifo_count, count_next;
  logic             fifo_empty, unused_full;
  entry_t           push_entry, head;

  assign mst_r_ready_o  = (outstanding_q != '0);
  assign mst_ar_valid_o = ar_valid_q;
  assign mst_ar_addr_o  = ar_addr_q;

  always_comb begin
    ar_hs = ar_valid_q & mst_ar_ready_i;
    r_hs  = mst_r_valid_i & mst_r_ready_o;

    case ({ar_hs, r_hs})
      2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
      2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase

    // A redirect flushes the queue, so neither a beat nor a pop lands in that cycle.
    push = r_hs & (drop_q == '0) & ~redirect_valid_i;
    pop  = ~fifo_empty & D_ready_i & ~redirect_valid_i;

    if (redirect_valid_i) begin
      count_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = fifo_count + CNT_W'(1);
        2'b01:   count_next = fifo_count - CNT_W'(1);
        default: count_next = fifo_count;
      endcase
    end

    drop_d   = drop_q;
    enq_pc_d = enq_pc_q;
    fetch_pc = fpc_q;
    if (redirect_valid_i) begin
      // Everything still in flight is stale, including an AR held on the bus that
      // has not handshaken yet: it must still complete, and its beat is discarded.
      drop_d   = outstanding_d + OUT_W'(ar_valid_q & ~ar_hs);
      enq_pc_d = redirect_pc_i;
      fetch_pc = redirect_pc_i;
    end else if (r_hs) begin
      if (drop_q != '0) drop_d = drop_q - OUT_W'(1);
      else              enq_pc_d = enq_pc_q + PC_W'(4);
    end

    // fpc is the address of the next AR not yet placed on the bus; it advances when
    // an AR is launched, which is equivalent to advancing on the handshake because
    // the launched address stays frozen until that handshake.
    ar_valid_d = ar_valid_q;
    ar_addr_d  = ar_addr_q;
    fpc_d      = fetch_pc;
    if (!ar_valid_q || ar_hs) begin
      ar_valid_d = ((SUM_W'(outstanding_d) + SUM_W'(count_next)) < SUM_W'(FIFO_DEPTH)) &&
                   (outstanding_d < OUT_W'(MAX_OUTSTANDING));
      if (ar_valid_d) begin
        ar_addr_d = fetch_pc;
        fpc_d     = fetch_pc + PC_W'(4);
      end
    end
  end

  always_comb begin
    push_entry.pc   = enq_pc_q;
    push_entry.inst = mst_r_data_i;
`ifdef IFU_ACCESS_FAULT_EN
    push_entry.fault = (mst_r_resp_i != AXI_RESP_OKAY);
`endif
  end

`ifndef IFU_ACCESS_FAULT_EN
  logic unused_resp;
  assign unused_resp = ^mst_r_resp_i;
`endif

  ifu_fifo #(
    .entry_t (entry_t),
    .DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (redirect_valid_i),
    .head_o      (head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty),
    .full_o      (unused_full)
  );

  assign f_valid_o = ~fifo_empty;
  assign pc_o      = fifo_empty ? RESET_PC : head.pc;
  assign inst_o    = fifo_empty ? INST_W'(NOP_INST) : head.inst;
`ifdef IFU_ACCESS_FAULT_EN
  assign fault_o   = ~fifo_empty & head.fault;
`else
  assign fault_o   = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fpc_q         <= RESET_PC;
      enq_pc_q      <= RESET_PC;
      ar_addr_q     <= RESET_PC;
      ar_valid_q    <= 1'b0;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fpc_q         <= fpc_d;
      enq_pc_q      <= enq_pc_d;
      ar_addr_q     <= ar_addr_d;
      ar_valid_q    <= ar_valid_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: bench for ifu_prefetch with an in-order AXI-lite slave model and a
// decode-stream reference (sequential PCs from the latest redirect target, instruction
// word a fixed hash of its address).
module tb_ifu_prefetch;

  localparam int unsigned MAXO   = 2;
  localparam int unsigned DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        f_valid, d_ready, fault;
  logic [31:0] pc, inst;
  logic        ar_valid, ar_ready, r_valid, r_ready;
  logic [31:0] ar_addr, r_data;
  logic [1:0]  r_resp;

  always #5 clk = ~clk;

  ifu_prefetch #(
    .PC_W(32), .INST_W(32), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RST_PC)
  ) dut (
    .clk_i(clk), .rst_i(rst_n),
    .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
    .f_valid_o(f_valid), .D_ready_i(d_ready),
    .pc_o(pc), .inst_o(inst), .fault_o(fault),
    .mst_ar_valid_o(ar_valid), .mst_ar_addr_o(ar_addr), .mst_ar_ready_i(ar_ready),
    .mst_r_valid_i(r_valid), .mst_r_data_i(r_data), .mst_r_resp_i(r_resp),
    .mst_r_ready_o(r_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory contents and bus-error map seen by the slave.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction
  function automatic logic mem_err(input logic [31:0] a);
    return a[7:2] == 6'd2;
  endfunction
  function automatic logic exp_fault(input logic [31:0] a);
`ifdef IFU_ACCESS_FAULT_EN
    return mem_err(a);
`else
    return 1'b0 & a[0];
`endif
  endfunction

  // Slave and reference state.
  logic [31:0] sq_addr[$];
  int          sq_due[$];
  logic [31:0] ar_log[$];
  int          cyc;
  int unsigned lat_min, lat_max, ar_pct, d_pct, r_pct, redir_pm;
  logic        redir_req;
  logic [31:0] redir_target;
  logic [31:0] exp_pc, ar_exp, prev_ar_addr, first_pop_pc;
  logic        prev_ar_pend, prev_redirect, want_first;
  int          pops, fv_count;

  task automatic model_clear();
    sq_addr.delete(); sq_due.delete(); ar_log.delete();
    exp_pc = RST_PC; ar_exp = RST_PC;
    prev_ar_pend = 1'b0; prev_redirect = 1'b0; want_first = 1'b0;
    cyc = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; d_ready = 1'b0;
    ar_ready = 1'b0; r_valid = 1'b0; r_data = '0; r_resp = 2'b00;
    @(negedge clk);
    check("rst_f_valid", f_valid, 0);
    check("rst_ar_valid", ar_valid, 0);
    check("rst_r_ready", r_ready, 0);
    check("rst_pc", pc, RST_PC);
    check("rst_inst", inst, NOP);
    check("rst_fault", fault, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic step();
    logic ar_hs, r_hs, pop, redir;
    logic [31:0] rp;
    if (prev_redirect) check("fvalid_after_redirect", f_valid, 0);
    if (prev_ar_pend) begin
      check("ar_valid_held", ar_valid, 1);
      check("ar_addr_held", ar_addr, prev_ar_addr);
    end
    check("r_ready", r_ready, sq_addr.size() > 0);
    check("outstanding_le_max", sq_addr.size() <= MAXO, 1);
    if (!f_valid) begin
      check("empty_pc", pc, RST_PC);
      check("empty_inst", inst, NOP);
      check("empty_fault", fault, 0);
    end else begin
      fv_count++;
    end
    if (ar_valid && !prev_ar_pend) begin
      check("ar_addr", ar_addr, ar_exp);
      ar_log.push_back(ar_addr);
      ar_exp += 32'd4;
    end

    ar_ready = ($urandom_range(99) < ar_pct);
    d_ready  = ($urandom_range(99) < d_pct);
    redir    = redir_req || ($urandom_range(999) < redir_pm);
    rp       = $urandom();
    rp[1:0]  = 2'b00;
    redirect_valid = redir;
    redirect_pc    = redir_req ? redir_target : rp;
    redir_req      = 1'b0;
    r_valid = (sq_addr.size() > 0) && (sq_due[0] <= cyc) && ($urandom_range(99) < r_pct);
    r_data  = (sq_addr.size() > 0) ? mem_word(sq_addr[0]) : 32'h0;
    r_resp  = ((sq_addr.size() > 0) && mem_err(sq_addr[0])) ? 2'b10 : 2'b00;

    ar_hs = ar_valid && ar_ready;
    r_hs  = r_valid && r_ready;
    pop   = f_valid && d_ready && !redir;
    if (pop) begin
      check("dec_pc", pc, exp_pc);
      check("dec_inst", inst, mem_word(exp_pc));
      check("dec_fault", fault, exp_fault(exp_pc));
      if (want_first) begin first_pop_pc = pc; want_first = 1'b0; end
      exp_pc += 32'd4;
      pops++;
    end
    if (r_hs) begin
      void'(sq_addr.pop_front());
      void'(sq_due.pop_front());
    end
    if (ar_hs) begin
      sq_addr.push_back(ar_addr);
      sq_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
    end
    if (redir) begin
      exp_pc = redirect_pc;
      ar_exp = redirect_pc;
      want_first = 1'b1;
      ar_log.delete();
    end
    prev_ar_pend  = ar_valid && !ar_ready;
    prev_ar_addr  = ar_addr;
    prev_redirect = redir;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int p0, drained;
    pops = 0; fv_count = 0; redir_req = 1'b0; redir_target = '0; first_pop_pc = '0;
    lat_min = 1; lat_max = 1; ar_pct = 100; d_pct = 100; r_pct = 100; redir_pm = 0;
    do_reset();

    // Sequential fetch from reset, latency-1 slave.
    run(4);
    fv_count = 0; p0 = pops;
    run(12);
    check("t1_ar0", ar_log[0], 32'h8000_0000);
    check("t1_ar1", ar_log[1], 32'h8000_0004);
    check("t1_ar2", ar_log[2], 32'h8000_0008);
    check("t1_fvalid_steady", fv_count, 12);
    check("t1_pops", pops - p0, 12);

    // Decode stalled: queue fills to exactly its depth, then drains without loss.
    d_pct = 0;
    run(20);
    check("t2_ar_valid_low", ar_valid, 0);
    check("t2_f_valid", f_valid, 1);
    check("t2_no_outstanding", sq_addr.size(), 0);
    ar_pct = 0; d_pct = 100; drained = 0;
    for (int i = 0; i < 10; i++) begin
      if (f_valid) drained++;
      step();
    end
    check("t2_buffered", drained, DEPTH);
    ar_pct = 100;
    run(10);

    // Redirect with two reads in flight.
    lat_min = 8; lat_max = 8;
    for (int i = 0; i < 40 && sq_addr.size() != MAXO; i++) step();
    check("t3_two_outstanding", sq_addr.size(), MAXO);
    check("t3_ar_idle", ar_valid, 0);
    redir_req = 1'b1; redir_target = 32'h8000_1000;
    run(40);
    check("t3_first_ar", ar_log[0], 32'h8000_1000);
    check("t3_first_pop", first_pop_pc, 32'h8000_1000);

    // Redirect coinciding with a pop and an R handshake.
    lat_min = 1; lat_max = 1;
    run(10);
    for (int i = 0; i < 20 && !(f_valid && sq_addr.size() > 0 && sq_due[0] <= cyc); i++) step();
    check("t4_setup", f_valid && sq_addr.size() > 0, 1);
    redir_req = 1'b1; redir_target = 32'h8000_2000;
    step();
    check("t4_empty_after", f_valid, 0);
    run(20);
    check("t4_first_pop", first_pop_pc, 32'h8000_2000);

    // AR stalled for 5 cycles, redirect in the second.
    run(10);
    ar_pct = 0;
    step();
    check("t5_ar_pending", ar_valid, 1);
    redir_req = 1'b1; redir_target = 32'h8000_3000;
    run(4);
    ar_pct = 100;
    run(20);
    check("t5_first_ar", ar_log[0], 32'h8000_3000);
    check("t5_first_pop", first_pop_pc, 32'h8000_3000);

    // PC wrap at the top of the address space.
    redir_req = 1'b1; redir_target = 32'hFFFF_FFF0;
    run(20);
    check("wrap_first_pop", first_pop_pc, 32'hFFFF_FFF0);

    // Randomised traffic with random redirects.
    p0 = pops;
    redir_pm = 20;
    for (int blk = 0; blk < 15; blk++) begin
      lat_min = 1;
      lat_max = $urandom_range(5, 1);
      ar_pct  = $urandom_range(100, 30);
      d_pct   = $urandom_range(100, 20);
      r_pct   = $urandom_range(100, 50);
      run(200);
    end
    check("rand_progress", pops - p0 > 200, 1);

    // Reset in the middle of traffic.
    do_reset();
    lat_min = 1; lat_max = 3; ar_pct = 80; d_pct = 80; r_pct = 90; redir_pm = 0;
    p0 = pops;
    run(200);
    check("post_reset_progress", pops - p0 > 50, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
